// File: rtl/selector_loader.sv
// selector_loader: framed byte-stream loader for a downstream mux routing map
module selector_loader #(
    parameter int INPUT_COUNT = 16,
    parameter int OUTPUT_COUNT = 16,
    parameter int TIMEOUT = 1000,
    localparam int SEL_W = $clog2(OUTPUT_COUNT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [7:0]                        in_data,
    output logic                              in_ready,
    output logic [0:SEL_W*OUTPUT_COUNT-1]     selectors,
    output logic                              updated,
    output logic                              error
);
    localparam int MAP_W = SEL_W * OUTPUT_COUNT;
    localparam int IW = $clog2(TIMEOUT + 1);

    function automatic logic [0:MAP_W-1] identity_map();
        logic [0:MAP_W-1] m;
        m = '0;
        for (int i = 0; i < OUTPUT_COUNT; i++) m[i*SEL_W +: SEL_W] = SEL_W'(i);
        return m;
    endfunction

    localparam logic [0:MAP_W-1] IDENTITY = identity_map();

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, COMMIT} state_t;

    state_t state, state_nx;
    logic [SEL_W-1:0] cnt;
    logic [7:0] csum;
    logic bad;
    logic [IW-1:0] idle_cnt;
    logic [0:MAP_W-1] shadow;
    logic err_nx;
    logic accept;
    logic timed_out;

    assign in_ready = state != COMMIT;
    assign accept = in_valid && in_ready;
    assign timed_out = !accept && idle_cnt == IW'(TIMEOUT - 1);

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    // next state and reject decision; a header byte inside a frame is plain data
    always_comb begin
        state_nx = state;
        err_nx = 1'b0;
        case (state)
            IDLE: state_nx = (accept && in_data == 8'hA5) ? PAYLOAD : IDLE;
            PAYLOAD: begin
                state_nx = (accept && cnt == SEL_W'(OUTPUT_COUNT - 1)) ? CHECK : timed_out ? IDLE : PAYLOAD;
                err_nx = timed_out;
            end
            CHECK: begin
                state_nx = accept ? ((in_data == csum && !bad) ? COMMIT : IDLE) : timed_out ? IDLE : CHECK;
                err_nx = accept ? (in_data != csum || bad) : timed_out;
            end
            default: state_nx = IDLE;
        endcase
    end

    // frame datapath: shadow capture, checksum, idle timer, commit and pulses
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            csum <= '0;
            bad <= 1'b0;
            idle_cnt <= '0;
            shadow <= IDENTITY;
            selectors <= IDENTITY;
            updated <= 1'b0;
            error <= 1'b0;
        end else begin
            error <= err_nx;
            updated <= state == COMMIT;
            idle_cnt <= ((state == PAYLOAD || state == CHECK) && !accept) ? idle_cnt + 1'b1 : '0;
            if (state == COMMIT) selectors <= shadow;
            if (state == IDLE) begin
                cnt <= '0;
                csum <= '0;
                bad <= 1'b0;
            end
            if (state == PAYLOAD && accept) begin
                shadow[cnt*SEL_W +: SEL_W] <= in_data[SEL_W-1:0];
                csum <= csum ^ in_data;
                bad <= bad || 32'(in_data) >= INPUT_COUNT;
                cnt <= cnt + 1'b1;
            end
        end
endmodule

// File: doc/selector_loader.md
SELECTOR_LOADER -- requirements
Module: selector_loader

Interface
REQ-001 Parameter INPUT_COUNT, default 16: number of mux source pins; indices at or above this value are illegal.
REQ-002 Parameter OUTPUT_COUNT, default 16: number of mux output pins, equal to the number of selector slices.
REQ-003 Parameter TIMEOUT, default 1000: maximum allowed idle cycles between bytes inside a frame.
REQ-004 Derived width SEL_W = $clog2(OUTPUT_COUNT) SHALL be used for each slice; INPUT_COUNT <= 2^SEL_W is required.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port in_valid, input, 1: in_data holds a byte this cycle.
REQ-008 Port in_data, input, 8: configuration byte stream.
REQ-009 Port in_ready, output, 1: the block accepts a byte when in_valid and in_ready are both high.
REQ-010 Port selectors, output, [0:SEL_W*OUTPUT_COUNT-1]: packed routing map driving the downstream mux; slice i = bits [i*SEL_W : (i+1)*SEL_W-1], MSB at the lowest index.
REQ-011 Port updated, output, 1: one-cycle pulse when a new map is committed.
REQ-012 Port error, output, 1: one-cycle pulse when a frame is rejected.

Function
REQ-013 Frame format SHALL be: header 0xA5, then OUTPUT_COUNT payload bytes (byte k = source index for output k, in the low SEL_W bits; upper bits must be zero), then one checksum byte equal to the XOR of all payload bytes.
REQ-014 The FSM SHALL have states IDLE, PAYLOAD, CHECK and COMMIT.
REQ-015 In IDLE, an accepted 0xA5 byte SHALL move to PAYLOAD with the byte counter at 0; any other accepted byte SHALL be dropped silently without raising error.
REQ-016 In PAYLOAD, each accepted byte SHALL be written to shadow slot [counter] and XORed into the running checksum; after byte OUTPUT_COUNT-1 the FSM SHALL move to CHECK.
REQ-017 Any payload byte with value >= INPUT_COUNT SHALL set a sticky bad flag for the frame; reception SHALL continue to the checksum byte.
REQ-018 In CHECK, the accepted byte SHALL move the FSM to COMMIT if it equals the running XOR and the bad flag is clear; otherwise the FSM SHALL pulse error and return to IDLE.
REQ-019 COMMIT SHALL last exactly one cycle: copy the shadow array to selectors, assert in_ready low, pulse updated, then return to IDLE.
REQ-020 Commit latency: selectors and updated SHALL change on the clock edge following the edge on which the checksum byte was accepted.
REQ-021 in_ready SHALL be high in IDLE, PAYLOAD and CHECK, and low only in COMMIT.
REQ-022 selectors SHALL change only in COMMIT; a partial or rejected frame SHALL leave it bit-identical.
REQ-023 In PAYLOAD or CHECK, an idle counter SHALL count cycles without an accepted byte and clear on each acceptance; reaching TIMEOUT SHALL pulse error and return to IDLE.
REQ-024 A 0xA5 byte arriving inside PAYLOAD or CHECK SHALL be treated as data, not as a resynchronising header.
REQ-025 updated and error SHALL never be high in the same cycle.

Reset
REQ-026 While rst is high, the FSM SHALL be in IDLE, counters, checksum and bad flag SHALL be 0, updated and error SHALL be 0, and in_ready SHALL be 1.
REQ-027 Reset SHALL load both the shadow and active maps with identity (slice i = i mod 2^SEL_W), so the downstream output i mirrors source i.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no updated or error pulse.

Verification
REQ-029 Release reset and check the idle state: selectors = 0x0123456789ABCDEF, in_ready = 1, updated = 0, error = 0.
REQ-030 Send a valid frame with A5, sixteen bytes of 0F, then checksum 00: updated pulses for one cycle one edge after the checksum byte, every slice reads 15, and in_ready is low for exactly that cycle.
REQ-031 Send A5, payload 00..0E plus 20, then the correct XOR: error pulses and selectors stay unchanged.
REQ-032 Send A5 and 5 payload bytes, then stop for 1000 cycles: error pulses at the timeout, then a following full valid frame commits correctly.
REQ-033 Send leading garbage 00 FF before a valid frame with a wrong checksum: no pulse on the garbage, error on the bad checksum, selectors unchanged.
REQ-034 Assert rst after 8 payload bytes: no pulses occur, selectors return to identity, and the next frame commits normally.
